// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Shares one memory port between the fetch and data masters, and
//            routes each in-order response back to the master that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        rsp_err
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [OUTSTANDING-1:0] r_ids;
    logic                   r_rsp_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    assign w_push  = mem_req & mem_addr_ok;
    assign w_pop   = mem_data_ok & ~w_empty;
    assign w_head  = r_ids[r_rptr];

    // Address phase: request and fields follow the granted master, zero otherwise.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (r_state)
            S_GNT_I: begin
                mem_req = inst_req & ~w_full;
                if (mem_req) begin
                    mem_size = 2'd2;
                    mem_addr = inst_addr;
                end
            end
            S_GNT_D: begin
                mem_req = data_req & ~w_full;
                if (mem_req) begin
                    mem_wr    = data_wr;
                    mem_size  = data_size;
                    mem_wstrb = data_wstrb;
                    mem_addr  = data_addr;
                    mem_wdata = data_wdata;
                end
            end
            default: ;
        endcase
    end

    assign inst_addr_ok = (r_state == S_GNT_I) & mem_req & mem_addr_ok;
    assign data_addr_ok = (r_state == S_GNT_D) & mem_req & mem_addr_ok;

    // After a handshake the other master wins a tie; from IDLE data wins.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (data_req)      w_state_nxt = S_GNT_D;
                else if (inst_req) w_state_nxt = S_GNT_I;
            end
            S_GNT_I: begin
                if (w_push) begin
                    if (data_req)      w_state_nxt = S_GNT_D;
                    else if (inst_req) w_state_nxt = S_GNT_I;
                end else if (inst_req) begin
                    w_state_nxt = S_GNT_I;
                end
            end
            S_GNT_D: begin
                if (w_push) begin
                    if (inst_req)      w_state_nxt = S_GNT_I;
                    else if (data_req) w_state_nxt = S_GNT_D;
                end else if (data_req) begin
                    w_state_nxt = S_GNT_D;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ID FIFO: one bit per in-flight request, 1 marks a data access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ids     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= (r_state == S_GNT_D);
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_data_ok && w_empty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign inst_data_ok = w_pop & ~w_head;
    assign data_data_ok = w_pop & w_head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign busy         = ~w_empty;
    assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Purpose  : Directed bench for mem_req_arbiter with a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int OUTSTANDING = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: owner 0 none, 1 inst, 2 data; queue holds the master of each in-flight request.
    int owner = 0;
    int nx_owner = 0;
    bit q[$];
    bit err = 1'b0;
    bit do_push, do_pop, do_err, push_id;

    always @(negedge clk) begin
        bit        full, e_req, e_iaok, e_daok, e_idok, e_ddok, hs;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_size;
        logic        e_wr;
        if (!resetn) begin
            owner = 0; q.delete(); err = 1'b0;
            do_push = 0; do_pop = 0; do_err = 0; nx_owner = 0;
        end
        full  = (q.size() == OUTSTANDING);
        e_req = (owner == 1) ? (inst_req && !full) : (owner == 2) ? (data_req && !full) : 1'b0;
        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_size = 0; e_wr = 0;
        if (e_req && owner == 1) begin e_addr = inst_addr; e_size = 2'd2; end
        if (e_req && owner == 2) begin
            e_addr = data_addr; e_wdata = data_wdata; e_wstrb = data_wstrb;
            e_size = data_size; e_wr = data_wr;
        end
        hs     = e_req && mem_addr_ok;
        e_iaok = hs && owner == 1;
        e_daok = hs && owner == 2;
        e_idok = mem_data_ok && q.size() > 0 && q[0] == 1'b0;
        e_ddok = mem_data_ok && q.size() > 0 && q[0] == 1'b1;
        chk("mem_req", mem_req, e_req);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_wstrb", mem_wstrb, e_wstrb);
        chk("mem_size", mem_size, e_size);
        chk("mem_wr", mem_wr, e_wr);
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
        chk("busy", busy, q.size() != 0);
        chk("rsp_err", rsp_err, err);
        do_push = hs;
        push_id = (owner == 2);
        do_pop  = mem_data_ok && q.size() > 0;
        do_err  = mem_data_ok && q.size() == 0;
        if (owner == 0 || hs) begin
            if (inst_req && data_req) nx_owner = (owner == 2) ? 1 : 2;
            else if (data_req)        nx_owner = 2;
            else if (inst_req)        nx_owner = 1;
            else                      nx_owner = 0;
        end else begin
            nx_owner = ((owner == 1 && inst_req) || (owner == 2 && data_req)) ? owner : 0;
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            owner = nx_owner;
            if (do_pop) void'(q.pop_front());
            if (do_err) err = 1'b1;
            if (do_push) q.push_back(push_id);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int grants[6];

    initial begin
        resetn = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        #2;
        chk("reset_mem_req", mem_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_err", rsp_err, 0);
        step(); step();
        resetn = 1;
        step();

        // Single fetch and its response two cycles after the handshake
        inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
        #3 chk("s1_idle_no_req", mem_req, 0);
        step();
        #3 chk("s1_mem_req", mem_req, 1);
        chk("s1_mem_addr", mem_addr, 32'h1C000000);
        step();
        inst_req = 0;
        #3 chk("s1_busy", busy, 1);
        step();
        mem_data_ok = 1; mem_rdata = 32'h02800C0C;
        #3 chk("s1_inst_data_ok", inst_data_ok, 1);
        chk("s1_data_data_ok", data_data_ok, 0);
        chk("s1_inst_rdata", inst_rdata, 32'h02800C0C);
        step();
        mem_data_ok = 0;
        #3 chk("s1_busy_clear", busy, 0);
        step();

        // Both masters rise in IDLE: data first, then fetch
        inst_req = 1; inst_addr = 32'h1C000004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h1000;
        data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
        step();
        #3 chk("s2_data_addr_ok", data_addr_ok, 1);
        chk("s2_inst_addr_ok", inst_addr_ok, 0);
        chk("s2_mem_addr", mem_addr, 32'h1000);
        chk("s2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        data_req = 0; data_wr = 0;
        #3 chk("s2_inst_granted", inst_addr_ok, 1);
        chk("s2_mem_addr_inst", mem_addr, 32'h1C000004);
        step();
        inst_req = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
        #3 chk("s2_rsp1_data", data_data_ok, 1);
        chk("s2_rsp1_busy", busy, 1);
        step();
        mem_rdata = 32'h22222222;
        #3 chk("s2_rsp2_inst", inst_data_ok, 1);
        chk("s2_rsp2_busy", busy, 1);
        step();
        mem_data_ok = 0;
        #3 chk("s2_idle_busy", busy, 0);
        step();

        // Both held: grants alternate D, I, D, I
        inst_req = 1; data_req = 1; data_wr = 0; data_wstrb = 0; data_addr = 32'h2000;
        step();
        for (int i = 0; i < 6; i++) begin
            #3 grants[i] = data_addr_ok ? 2 : (inst_addr_ok ? 1 : 0);
            step();
            mem_data_ok = 1;
        end
        inst_req = 0; data_req = 0;
        step();
        mem_data_ok = 0;
        for (int i = 0; i < 6; i++) chk($sformatf("s3_grant%0d", i), grants[i], (i % 2 == 0) ? 2 : 1);
        step();

        // Full FIFO blocks a third request until one response returns
        inst_req = 1; inst_addr = 32'h1C000100;
        step(); step(); step();
        #3 chk("s4_full_no_req", mem_req, 0);
        chk("s4_full_busy", busy, 1);
        step();
        mem_data_ok = 1;
        #3 chk("s4_pop_cycle_no_req", mem_req, 0);
        step();
        mem_data_ok = 0;
        #3 chk("s4_req_reasserts", mem_req, 1);
        step();
        inst_req = 0; mem_data_ok = 1;
        step(); step();
        mem_data_ok = 0;
        step();

        // Response with nothing outstanding, then reset mid-transfer
        mem_data_ok = 1;
        #3 chk("s5_no_inst_dok", inst_data_ok, 0);
        chk("s5_no_data_dok", data_data_ok, 0);
        step();
        mem_data_ok = 0;
        #3 chk("s5_rsp_err_set", rsp_err, 1);
        step();
        #3 chk("s5_rsp_err_sticky", rsp_err, 1);
        inst_req = 1;
        step(); step();
        inst_req = 0;
        #3 chk("s5_one_outstanding", busy, 1);
        step();
        #1 resetn = 0;
        #1 chk("s5_async_busy", busy, 0);
        chk("s5_async_rsp_err", rsp_err, 0);
        chk("s5_async_mem_req", mem_req, 0);
        step();
        resetn = 1; mem_data_ok = 1;
        #3 chk("s5_stale_no_dok", inst_data_ok | data_data_ok, 0);
        step();
        mem_data_ok = 0;
        #3 chk("s5_stale_rsp_err", rsp_err, 1);
        step();

        // Data master drops an unaccepted request
        mem_addr_ok = 0; data_req = 1; data_addr = 32'h3000;
        step();
        #3 chk("s6_gnt_d_req", mem_req, 1);
        chk("s6_not_accepted", data_addr_ok, 0);
        step();
        data_req = 0;
        step();
        data_req = 1;
        #3 chk("s6_back_to_idle", mem_req, 0);
        chk("s6_no_push", busy, 0);
        step();
        #3 chk("s6_regrant", mem_req, 1);
        step();
        data_req = 0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-master arbiter that shares the CPU's single SRAM-like memory port between instruction fetch and the MEM stage's data accesses. It sits between the pipeline's `inst_*` and `data_*` request/response interfaces and the downstream `mem_*` interface, which feeds the bridge or data SRAM. It grants one address phase at a time, with priority plus anti-starvation alternation. It tracks in-flight requests in an ID FIFO so that each in-order `mem_data_ok` is routed back to the master that issued it.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered requests; must be a power of two, at least 2.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `inst_req` input 1: fetch request, held until `inst_addr_ok`.
- `inst_addr` input 32: fetch address.
- `inst_addr_ok` output 1: fetch address phase accepted.
- `inst_data_ok` output 1: fetch response valid.
- `inst_rdata` output 32: fetch read data.
- `data_req` input 1: data request, held until `data_addr_ok`.
- `data_wr` input 1: 1 = write, 0 = read.
- `data_size` input 2: 0 = byte, 1 = half, 2 = word.
- `data_wstrb` input 4: byte write strobes.
- `data_addr` input 32: data address.
- `data_wdata` input 32: store data.
- `data_addr_ok` output 1: data address phase accepted.
- `data_data_ok` output 1: data response valid.
- `data_rdata` output 32: load data.
- `mem_req` output 1: request to the shared port.
- `mem_wr` output 1: write flag for the shared port.
- `mem_size` output 2: access size for the shared port.
- `mem_wstrb` output 4: write strobes for the shared port.
- `mem_addr` output 32: address for the shared port.
- `mem_wdata` output 32: write data for the shared port.
- `mem_addr_ok` input 1: downstream accepted the address phase.
- `mem_data_ok` input 1: downstream response; responses return strictly in order.
- `mem_rdata` input 32: downstream read data.
- `busy` output 1: outstanding count is nonzero.
- `rsp_err` output 1: sticky flag; a response arrived while nothing was outstanding.

## Operation
- Grant FSM has three states: IDLE, GNT_I, GNT_D.
  - In IDLE, `mem_req` = 0.
  - In GNT_I, `mem_req` = `inst_req` & ~full, and the `mem_*` fields carry inst values: `wr` = 0, `size` = 2, `wstrb` = 0, `wdata` = 0.
  - In GNT_D, `mem_req` = `data_req` & ~full, and the `mem_*` fields carry the `data_*` values.
  - When `mem_req` = 0, `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_size` and `mem_wr` are driven 0.
- `inst_addr_ok` = (state == GNT_I) & `mem_req` & `mem_addr_ok`. `data_addr_ok` is the same with GNT_D.
- Next-state choice after a handshake or from IDLE:
  - Only one request pending: grant that master.
  - Both pending from IDLE: GNT_D (data wins).
  - Both pending after a handshake: grant the master not just served (alternation).
  - Neither pending: IDLE.
- A granted master that drops its req before handshake causes a return to IDLE on the next edge. Grant never switches while the granted req is held and unaccepted.
- ID FIFO, depth `OUTSTANDING`, one bit per entry (0 = inst, 1 = data).
  - Push happens on `mem_req` & `mem_addr_ok`.
  - Pop happens on `mem_data_ok` when count > 0.
  - full = (count == `OUTSTANDING`), evaluated from the registered count. A same-cycle pop does not unblock a push.
- Response routing:
  - `inst_data_ok` = `mem_data_ok` & nonempty & head == 0.
  - `data_data_ok` = `mem_data_ok` & nonempty & head == 1.
  - `inst_rdata` = `data_rdata` = `mem_rdata`, unconditionally.
- Pointers wrap modulo `OUTSTANDING`. Count width is clog2(`OUTSTANDING`) + 1.
- `mem_data_ok` with count == 0: no pop, no master data_ok, `rsp_err` set to 1 until reset.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset (`resetn` low, asynchronous) clears:
  - state → IDLE
  - count, read pointer and write pointer → 0
  - `rsp_err` → 0
- Consequently all outputs read 0 during reset: `mem_req`, both addr_ok, both data_ok, `busy`.
- Reset mid-transaction discards all FIFO contents. Stale downstream responses after reset set `rsp_err`.
- Grant latency: a req rising in IDLE produces `mem_req` on the next cycle. Back-to-back grants after a handshake need no IDLE bubble.
- Address-phase outputs and data_ok outputs are combinational from the inputs and registered state, with zero added latency. The FIFO updates on the clock edge of the handshake.
- `busy` is registered-derived, count != 0.

## Test plan
- Reset, then `inst_req` = 1 at `inst_addr` = 0x1C000000 with `mem_addr_ok` tied 1.
  - Cycle 1: `mem_req` = 1, `mem_addr` = 0x1C000000.
  - `mem_data_ok` two cycles later with `mem_rdata` = 0x02800C0C: only `inst_data_ok` pulses, with that data.
- `inst_req` and `data_req` (write, `data_addr` = 0x1000, `data_wstrb` = 0xF, `data_wdata` = 0xDEADBEEF) both rise in IDLE.
  - Data granted first, then inst.
  - Two in-order responses go to data then inst.
  - `busy` = 1 until the second response.
- Both reqs held continuously, `mem_addr_ok` = 1, responses returned promptly.
  - Grants alternate D, I, D, I.
  - No master waits more than one handshake.
- `OUTSTANDING` = 2, `mem_data_ok` held 0, three requests.
  - Third request: `mem_req` = 0 while full.
  - One `mem_data_ok` → `mem_req` reasserts the following cycle.
- `mem_data_ok` pulse with count 0: `rsp_err` = 1 and stays 1; no master data_ok.
  - Then `resetn` low mid-transfer with one outstanding: all counters and `rsp_err` clear asynchronously.
- `data_req` dropped while GNT_D and unaccepted: state returns to IDLE next cycle, no FIFO push.
